// File: rtl/seq_checker_pkg.sv
// Shared types and helpers for the counter-code sequence checker.
// Holds the FSM states, the illegal code and the successor function.
package seq_checker_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [2:0] ILLEGAL_CODE = 3'b011;

  // Successor along 000-001-010-100-101-110-111-000
  function automatic logic [2:0] next_code(input logic [2:0] c);
    logic [2:0] n;
    n = 3'b000;
    case (c)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b010;
      3'b010:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b000;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic is_legal(input logic [2:0] c);
    return c != ILLEGAL_CODE;
  endfunction

endpackage

// File: rtl/seq_checker_sat_cnt8.sv
// 8-bit saturating event counter.
// A synchronous clear takes priority over a coincident increment.
module sat_cnt8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc && cnt != 8'hff) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Lock/unlock checker for a 3-bit sequence counter code stream.
// Hunts for LOCK_CNT good steps, then flags bad samples while locked.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] code_in,
  input  logic       code_vld,
  input  logic       clr_err,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [2:0] exp_code
);

  localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_CNT);

  state_t     state;
  logic [2:0] prev;
  logic       have_prev;
  logic [2:0] good_run;
  logic [2:0] bad_run;

  logic       legal;
  logic       good;
  logic       bad_hit;
  logic [2:0] good_inc;
  logic [2:0] bad_inc;

  assign legal    = is_legal(code_in);
  assign good     = have_prev && legal &&
                    (code_in == next_code(prev));
  assign bad_hit  = code_vld && (state == LOCKED) && !good;
  assign good_inc = good_run + 3'd1;
  assign bad_inc  = bad_run + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      prev      <= 3'b000;
      have_prev <= 1'b0;
      good_run  <= 3'd0;
      bad_run   <= 3'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      exp_code  <= 3'b000;
    end else begin
      err <= 1'b0;
      if (code_vld) begin
        unique case (state)
          HUNT: begin
            if (legal) begin
              prev      <= code_in;
              have_prev <= 1'b1;
              exp_code  <= next_code(code_in);
              if (good) begin
                good_run <= good_inc;
                if (good_inc == LOCK_C) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  bad_run <= 3'd0;
                end
              end else begin
                good_run <= 3'd0;
              end
            end else begin
              have_prev <= 1'b0;
              good_run  <= 3'd0;
              exp_code  <= 3'b000;
            end
          end
          LOCKED: begin
            if (good) begin
              prev     <= code_in;
              bad_run  <= 3'd0;
              exp_code <= next_code(code_in);
            end else begin
              err     <= 1'b1;
              bad_run <= bad_inc;
              // An illegal code keeps the old reference
              if (legal) begin
                prev     <= code_in;
                exp_code <= next_code(code_in);
              end
              if (bad_inc == UNLOCK_C) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_run <= 3'd0;
                if (!legal) begin
                  have_prev <= 1'b0;
                  exp_code  <= 3'b000;
                end
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_cnt8 u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_err),
    .inc     (bad_hit),
    .cnt     (err_cnt)
  );

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a ring-index reference model.
// Checks every negedge plus hand-computed literal points.
module tb_seq_checker;

  localparam int LOCK   = 3;
  localparam int UNLOCK = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] code_in;
  logic       code_vld;
  logic       clr_err;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [2:0] exp_code;

  int total = 0;
  int bad   = 0;

  logic [2:0] ring [7] = '{3'd0, 3'd1, 3'd2, 3'd4,
                           3'd5, 3'd6, 3'd7};

  // Model: reference held as a position in the legal ring
  bit m_locked = 0;
  bit m_err    = 0;
  int m_cnt    = 0;
  bit m_have   = 0;
  int m_pidx   = 0;
  int m_good   = 0;
  int m_bad    = 0;

  int drv_p;

  seq_checker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .code_in  (code_in),
    .code_vld (code_vld),
    .clr_err  (clr_err),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .exp_code (exp_code)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [2:0] c);
    for (int i = 0; i < 7; i++)
      if (ring[i] == c) return i;
    return -1;
  endfunction

  function automatic int m_exp();
    return m_have ? int'(ring[(m_pidx + 1) % 7]) : 0;
  endfunction

  task automatic check(input string name, input int act,
                       input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_locked = 0; m_err = 0; m_cnt = 0;
      m_have = 0; m_pidx = 0; m_good = 0; m_bad = 0;
    end else begin
      int  ix;
      bit  lg, gd;
      m_err = 0;
      if (code_vld) begin
        ix = idx_of(code_in);
        lg = (ix >= 0);
        gd = m_have && lg && (ix == (m_pidx + 1) % 7);
        if (!m_locked) begin
          if (lg) begin
            m_have = 1;
            m_pidx = ix;
            m_good = gd ? m_good + 1 : 0;
            if (m_good == LOCK) begin
              m_locked = 1;
              m_bad = 0;
            end
          end else begin
            m_have = 0;
            m_good = 0;
          end
        end else if (gd) begin
          m_pidx = ix;
          m_bad = 0;
        end else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
          m_bad++;
          if (lg) m_pidx = ix;
          if (m_bad == UNLOCK) begin
            m_locked = 0;
            m_good = 0;
            if (!lg) m_have = 0;
          end
        end
      end
      if (clr_err) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    check("locked", int'(locked), int'(m_locked));
    check("err", int'(err), int'(m_err));
    check("err_cnt", int'(err_cnt), m_cnt);
    check("exp_code", int'(exp_code), m_exp());
  end

  task automatic send(input logic [2:0] c, input logic clr = 1'b0);
    code_in  = c;
    code_vld = 1'b1;
    clr_err  = clr;
    @(negedge clk);
    code_vld = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      code_in = 3'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic lit(input string tag, input int l, input int e,
                     input int cn, input int ex);
    check({tag, ".locked"}, int'(locked), l);
    check({tag, ".err"}, int'(err), e);
    check({tag, ".cnt"}, int'(err_cnt), cn);
    check({tag, ".exp"}, int'(exp_code), ex);
  endtask

  // One bad step (skip a code) then one good step
  task automatic err_pair();
    drv_p = (drv_p + 2) % 7;
    send(ring[drv_p]);
    drv_p = (drv_p + 1) % 7;
    send(ring[drv_p]);
  endtask

  initial begin
    reset_n  = 1'b0;
    code_in  = 3'd0;
    code_vld = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lit("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk);

    send(3'b000); send(3'b001); send(3'b010);
    lit("pre_lock", 0, 0, 0, 4);
    send(3'b100);
    lit("lock", 1, 0, 0, 5);

    send(3'b110);
    lit("bad110", 1, 1, 1, 7);
    idle(1);
    lit("pulse_end", 1, 0, 1, 7);
    send(3'b111);
    lit("good111", 1, 0, 1, 0);
    send(3'b011);
    lit("single_bad", 1, 1, 2, 0);
    send(3'b000);
    lit("recover", 1, 0, 2, 1);

    send(3'b011);
    lit("bad1", 1, 1, 3, 1);
    send(3'b011);
    lit("unlock", 0, 1, 4, 0);

    send(3'b000); send(3'b001); send(3'b010);
    lit("relock3", 0, 0, 4, 4);
    send(3'b100);
    lit("relock4", 1, 0, 4, 5);

    idle(10);
    lit("novld", 1, 0, 4, 5);

    drv_p = 3;
    for (int i = 0; i < 255; i++) err_pair();
    lit("sat", 1, 0, 255, int'(ring[(drv_p + 1) % 7]));
    drv_p = (drv_p + 2) % 7;
    send(ring[drv_p]);
    lit("sat_bad", 1, 1, 255, int'(ring[(drv_p + 1) % 7]));
    drv_p = (drv_p + 1) % 7;
    send(ring[drv_p]);
    drv_p = (drv_p + 2) % 7;
    send(ring[drv_p], 1'b1);
    lit("clr_win", 1, 1, 0, int'(ring[(drv_p + 1) % 7]));
    drv_p = (drv_p + 1) % 7;
    send(ring[drv_p]);

    for (int i = 0; i < 5; i++) err_pair();
    lit("cnt5", 1, 0, 5, int'(ring[(drv_p + 1) % 7]));

    #2 reset_n = 1'b0;
    #1 lit("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send(3'b001); send(3'b010); send(3'b100);
    lit("post_rst", 0, 0, 0, 5);
    send(3'b101);
    lit("post_lock", 1, 0, 0, 6);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
